// File: rtl/vga_frame_monitor.sv
// Pixel-clock sink for the VGA generator stream: rebuilds x/y from sync/blank,
// checks line/frame geometry, accumulates an RGB checksum and samples one probe pixel.
module vga_frame_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_TOTAL  = 800
) (
    input  logic        VGA_clk,
    input  logic        rst,
    input  logic [7:0]  VGA_R,
    input  logic [7:0]  VGA_G,
    input  logic [7:0]  VGA_B,
    input  logic        VGA_hSync,
    input  logic        VGA_vSync,
    input  logic        blank_n,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic [7:0]  probe_R,
    output logic [7:0]  probe_G,
    output logic [7:0]  probe_B,
    output logic        probe_valid,
    output logic [15:0] checksum,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        err_h,
    output logic        err_v,
    output logic        locked,
    output logic [7:0]  frame_count
);

    localparam logic [9:0]  H_ACT = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT = 10'(V_ACTIVE);
    localparam logic [10:0] H_TOT = 11'(H_TOTAL);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_FRAME} state_t;

    // input stages
    logic [7:0] r_s1_r, r_s1_g, r_s1_b;
    logic       r_s1_hs, r_s1_vs, r_s1_bl;
    logic [9:0] r_s1_px, r_s1_py;
    logic       r_s2_hs, r_s2_vs, r_s2_bl;

    always_ff @(posedge VGA_clk or posedge rst) begin
        if (rst) begin
            r_s1_r  <= '0;
            r_s1_g  <= '0;
            r_s1_b  <= '0;
            r_s1_hs <= 1'b0;
            r_s1_vs <= 1'b0;
            r_s1_bl <= 1'b0;
            r_s1_px <= '0;
            r_s1_py <= '0;
            r_s2_hs <= 1'b0;
            r_s2_vs <= 1'b0;
            r_s2_bl <= 1'b0;
        end else begin
            r_s1_r  <= VGA_R;
            r_s1_g  <= VGA_G;
            r_s1_b  <= VGA_B;
            r_s1_hs <= VGA_hSync;
            r_s1_vs <= VGA_vSync;
            r_s1_bl <= blank_n;
            r_s1_px <= probe_x;
            r_s1_py <= probe_y;
            r_s2_hs <= r_s1_hs;
            r_s2_vs <= r_s1_vs;
            r_s2_bl <= r_s1_bl;
        end
    end

    logic w_hs_fall, w_vs_fall, w_bl_fall;
    assign w_hs_fall = r_s2_hs & ~r_s1_hs;
    assign w_vs_fall = r_s2_vs & ~r_s1_vs;
    assign w_bl_fall = r_s2_bl & ~r_s1_bl;

    // state machine
    state_t r_state, w_state_nxt;
    logic   w_close;

    always_ff @(posedge VGA_clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_close     = 1'b0;
        case (r_state)
            S_IDLE:  w_state_nxt = S_ARM;
            S_ARM:   if (w_vs_fall) w_state_nxt = S_FRAME;
            S_FRAME: if (w_vs_fall) w_close = 1'b1;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // working registers for the open frame
    logic [9:0]  r_x, r_y;
    logic [10:0] r_hcnt;
    logic        r_hseen, r_errh_w, r_errv_w, r_phit_w;
    logic [15:0] r_cks_w;
    logic [7:0]  r_pr_w, r_pg_w, r_pb_w;

    logic [9:0]  w_x_nxt, w_y_nxt;
    logic [10:0] w_hcnt_nxt;
    logic        w_hseen_nxt, w_errh_nxt, w_errv_nxt, w_phit_nxt;
    logic [15:0] w_cks_nxt;
    logic [7:0]  w_pr_nxt, w_pg_nxt, w_pb_nxt;
    logic        w_probe_in;

    assign w_probe_in = (r_s1_px < H_ACT) && (r_s1_py < V_ACT);

    // pixel effects first, then the line edge, so a same-cycle close sees the counted line
    always_comb begin
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_hcnt_nxt  = (r_hcnt == 11'h7FF) ? r_hcnt : r_hcnt + 11'd1;
        w_hseen_nxt = r_hseen;
        w_errh_nxt  = r_errh_w;
        w_cks_nxt   = r_cks_w;
        w_phit_nxt  = r_phit_w;
        w_pr_nxt    = r_pr_w;
        w_pg_nxt    = r_pg_w;
        w_pb_nxt    = r_pb_w;
        if (r_s1_bl) begin
            w_x_nxt   = (r_x == 10'h3FF) ? r_x : r_x + 10'd1;
            w_cks_nxt = r_cks_w + {8'h00, r_s1_r ^ r_s1_g ^ r_s1_b};
            if (w_probe_in && r_x == r_s1_px && r_y == r_s1_py) begin
                w_phit_nxt = 1'b1;
                w_pr_nxt   = r_s1_r;
                w_pg_nxt   = r_s1_g;
                w_pb_nxt   = r_s1_b;
            end
        end
        if (w_bl_fall) begin
            if (r_x != H_ACT) w_errh_nxt = 1'b1;
            w_y_nxt = (r_y == 10'h3FF) ? r_y : r_y + 10'd1;
            w_x_nxt = '0;
        end
        if (w_hs_fall) begin
            if (r_hseen && r_hcnt != H_TOT) w_errh_nxt = 1'b1;
            w_hcnt_nxt  = 11'd1;
            w_hseen_nxt = 1'b1;
        end
        w_errv_nxt = r_errv_w | r_s1_bl | (w_y_nxt != V_ACT);
    end

    always_ff @(posedge VGA_clk or posedge rst) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_hcnt   <= '0;
            r_hseen  <= 1'b0;
            r_errh_w <= 1'b0;
            r_errv_w <= 1'b0;
            r_cks_w  <= '0;
            r_phit_w <= 1'b0;
            r_pr_w   <= '0;
            r_pg_w   <= '0;
            r_pb_w   <= '0;
        end else if (r_state != S_FRAME || w_close) begin
            r_x      <= '0;
            r_y      <= '0;
            r_hcnt   <= '0;
            r_hseen  <= 1'b0;
            r_errh_w <= 1'b0;
            r_errv_w <= 1'b0;
            r_cks_w  <= '0;
            r_phit_w <= 1'b0;
            r_pr_w   <= '0;
            r_pg_w   <= '0;
            r_pb_w   <= '0;
        end else begin
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_hcnt   <= w_hcnt_nxt;
            r_hseen  <= w_hseen_nxt;
            r_errh_w <= w_errh_nxt;
            r_errv_w <= 1'b0 | r_errv_w;
            r_cks_w  <= w_cks_nxt;
            r_phit_w <= w_phit_nxt;
            r_pr_w   <= w_pr_nxt;
            r_pg_w   <= w_pg_nxt;
            r_pb_w   <= w_pb_nxt;
        end
    end

    // frame-close results
    logic [1:0] r_run, w_run_nxt;
    logic       w_good;

    assign w_good    = ~(w_errh_nxt | w_errv_nxt);
    assign w_run_nxt = !w_good ? 2'd0 : (r_run == 2'd2) ? 2'd2 : r_run + 2'd1;

    always_ff @(posedge VGA_clk or posedge rst) begin
        if (rst) begin
            probe_R     <= '0;
            probe_G     <= '0;
            probe_B     <= '0;
            probe_valid <= 1'b0;
            checksum    <= '0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            err_h       <= 1'b0;
            err_v       <= 1'b0;
            locked      <= 1'b0;
            frame_count <= '0;
            r_run       <= '0;
        end else begin
            frame_done <= w_close;
            if (w_close) begin
                probe_R     <= w_pr_nxt;
                probe_G     <= w_pg_nxt;
                probe_B     <= w_pb_nxt;
                probe_valid <= w_phit_nxt;
                checksum    <= w_cks_nxt;
                frame_ok    <= w_good;
                err_h       <= w_errh_nxt;
                err_v       <= w_errv_nxt;
                frame_count <= frame_count + 8'd1;
                r_run       <= w_run_nxt;
                locked      <= (w_run_nxt == 2'd2);
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Scoreboard bench for vga_frame_monitor on a reduced 16x8 raster (24 clocks/line, 10 lines/frame).
module tb_vga_frame_monitor;

    localparam int HA = 16;
    localparam int VA = 8;
    localparam int HT = 24;

    logic        VGA_clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  vga_r = '0, vga_g = '0, vga_b = '0;
    logic        hs = 1'b1, vs = 1'b1, bl = 1'b0;
    logic [9:0]  px = '0, py = '0;
    logic [7:0]  probe_R, probe_G, probe_B, frame_count;
    logic        probe_valid, frame_done, frame_ok, err_h, err_v, locked;
    logic [15:0] checksum;

    vga_frame_monitor #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT)) dut (
        .VGA_clk(VGA_clk), .rst(rst),
        .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
        .VGA_hSync(hs), .VGA_vSync(vs), .blank_n(bl),
        .probe_x(px), .probe_y(py),
        .probe_R(probe_R), .probe_G(probe_G), .probe_B(probe_B),
        .probe_valid(probe_valid), .checksum(checksum),
        .frame_done(frame_done), .frame_ok(frame_ok),
        .err_h(err_h), .err_v(err_v), .locked(locked),
        .frame_count(frame_count)
    );

    always #5 VGA_clk = ~VGA_clk;

    typedef struct {
        logic [15:0] cks;
        logic [7:0]  pr, pg, pb;
        logic        pv, ok, eh, ev, lk;
        logic [7:0]  cnt;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] cks, input logic [7:0] pr, pg, pb,
                                input logic pv, ok, eh, ev, lk, input logic [7:0] cnt);
        exp_t e;
        e.cks = cks; e.pr = pr; e.pg = pg; e.pb = pb;
        e.pv = pv; e.ok = ok; e.eh = eh; e.ev = ev; e.lk = lk; e.cnt = cnt;
        return e;
    endfunction

    // monitor: one pop per frame_done
    always @(negedge VGA_clk) begin
        if (frame_done) begin
            if (q.size() == 0) begin
                chk("unexpected_frame_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("checksum",    checksum,    e.cks);
                chk("probe_R",     probe_R,     e.pr);
                chk("probe_G",     probe_G,     e.pg);
                chk("probe_B",     probe_B,     e.pb);
                chk("probe_valid", probe_valid, e.pv);
                chk("frame_ok",    frame_ok,    e.ok);
                chk("err_h",       err_h,       e.eh);
                chk("err_v",       err_v,       e.ev);
                chk("locked",      locked,      e.lk);
                chk("frame_count", frame_count, e.cnt);
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_checksum"},    checksum,    0);
        chk({tag, "_probe_R"},     probe_R,     0);
        chk({tag, "_probe_valid"}, probe_valid, 0);
        chk({tag, "_frame_done"},  frame_done,  0);
        chk({tag, "_frame_ok"},    frame_ok,    0);
        chk({tag, "_err_h"},       err_h,       0);
        chk({tag, "_err_v"},       err_v,       0);
        chk({tag, "_locked"},      locked,      0);
        chk({tag, "_frame_count"}, frame_count, 0);
    endtask

    // one line; cut_at>=0 drops vSync while blank_n is still high at that column
    task automatic drive_line(input int nact, input bit vlow, input bit grad, input int ln, input int cut_at);
        for (int c = 0; c < HT; c++) begin
            @(negedge VGA_clk);
            hs = !(c >= 18 && c <= 20);
            if (cut_at >= 0) begin
                vs = (c < cut_at);
                bl = (c <= cut_at);
            end else begin
                vs = !vlow;
                bl = (c < nact);
            end
            if (cut_at >= 0 && c == cut_at) begin
                vga_r = 8'h00; vga_g = 8'h00; vga_b = 8'h00;
            end else if (grad) begin
                vga_r = 8'(c); vga_g = 8'(ln); vga_b = 8'h00;
            end else begin
                vga_r = 8'hFF; vga_g = 8'h00; vga_b = 8'h00;
            end
        end
    endtask

    task automatic arm();
        drive_line(0, 1'b1, 1'b0, 8, -1);
        drive_line(0, 1'b0, 1'b0, 9, -1);
    endtask

    // active lines 0..7, vSync low on line 8 closes this frame's content
    task automatic drive_frame(input int act_lines, input int short_ln, input bit cut,
                               input bit grad, input exp_t e);
        q.push_back(e);
        for (int ln = 0; ln < VA; ln++) begin
            if (cut && ln == VA - 1)
                drive_line(0, 1'b0, grad, ln, 8);
            else
                drive_line((ln < act_lines) ? ((ln == short_ln) ? HA - 1 : HA) : 0, 1'b0, grad, ln, -1);
        end
        drive_line(0, 1'b1, grad, 8, -1);
        drive_line(0, 1'b0, grad, 9, -1);
    endtask

    initial begin
        repeat (3) @(negedge VGA_clk);
        check_zero("reset");
        rst = 1'b0;
        drive_line(0, 1'b0, 1'b0, 9, -1);
        arm();

        px = 10'd3; py = 10'd2;
        drive_frame(8, -1, 0, 0, mk(16'h7F80, 8'hFF, 8'h00, 8'h00, 1, 1, 0, 0, 0, 8'd1));
        drive_frame(8, -1, 0, 0, mk(16'h7F80, 8'hFF, 8'h00, 8'h00, 1, 1, 0, 0, 1, 8'd2));
        px = 10'd10; py = 10'd5;
        drive_frame(8, -1, 0, 1, mk(16'h03C0, 8'h0A, 8'h05, 8'h00, 1, 1, 0, 0, 1, 8'd3));
        px = 10'd15; py = 10'd7;
        drive_frame(8, -1, 0, 1, mk(16'h03C0, 8'h0F, 8'h07, 8'h00, 1, 1, 0, 0, 1, 8'd4));
        px = 10'd3; py = 10'd2;
        drive_frame(8, 3, 0, 0, mk(16'h7E81, 8'hFF, 8'h00, 8'h00, 1, 0, 1, 0, 0, 8'd5));
        drive_frame(8, -1, 0, 0, mk(16'h7F80, 8'hFF, 8'h00, 8'h00, 1, 1, 0, 0, 0, 8'd6));
        drive_frame(8, -1, 0, 0, mk(16'h7F80, 8'hFF, 8'h00, 8'h00, 1, 1, 0, 0, 1, 8'd7));
        py = 10'd8;
        drive_frame(8, -1, 0, 0, mk(16'h7F80, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 1, 8'd8));
        py = 10'd2;
        drive_frame(7, -1, 0, 0, mk(16'h6F90, 8'hFF, 8'h00, 8'h00, 1, 0, 0, 1, 0, 8'd9));
        drive_frame(8, -1, 1, 0, mk(16'h7788, 8'hFF, 8'h00, 8'h00, 1, 0, 0, 1, 0, 8'd10));

        // reset in the middle of the next frame
        drive_line(HA, 1'b0, 1'b0, 0, -1);
        drive_line(HA, 1'b0, 1'b0, 1, -1);
        @(negedge VGA_clk);
        rst = 1'b1;
        #1;
        check_zero("rst_mid");
        repeat (3) @(negedge VGA_clk);
        rst = 1'b0;
        drive_line(0, 1'b0, 1'b0, 9, -1);
        arm();
        drive_frame(8, -1, 0, 0, mk(16'h7F80, 8'hFF, 8'h00, 8'h00, 1, 1, 0, 0, 0, 8'd1));
        drive_frame(8, -1, 0, 0, mk(16'h7F80, 8'hFF, 8'h00, 8'h00, 1, 1, 0, 0, 1, 8'd2));
        drive_line(0, 1'b0, 1'b0, 0, -1);

        chk("pending_frames", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
